// File: rtl/serial_tx_launcher.sv
// MSB-first serializer with selectable launch edge and a leading training burst.
// Control inputs from I2C are resynchronized here before use.
module serial_tx_launcher #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] TRAIN_WORD   = 8'hAA,
    parameter logic [WIDTH-1:0] IDLE_WORD    = 8'h3C,
    parameter int               TRAIN_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             train_start_asyn,
    input  logic             falling_edge_launch_asyn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             training,
    output logic             train_done,
    output logic             launch_edge
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        TRAIN,
        DATA
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [15:0]      train_cnt;
    logic [1:0]       ts_sync;
    logic             ts_d;
    logic [1:0]       fl_sync;
    logic             neg_bit;

    logic             train_pulse;
    logic             word_end;
    logic             train_last;
    logic             accept;
    logic [WIDTH-1:0] next_word;
    logic [WIDTH-1:0] shifted;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ts_sync <= '0;
            ts_d    <= 1'b0;
            fl_sync <= '0;
        end else begin
            ts_sync <= {ts_sync[0], train_start_asyn};
            ts_d    <= ts_sync[1];
            fl_sync <= {fl_sync[0], falling_edge_launch_asyn};
        end
    end

    assign train_pulse = ts_sync[1] & ~ts_d;
    assign word_end    = bit_cnt == BIT_LAST;
    assign train_last  = train_cnt == TRAIN_LAST;
    assign din_ready   = ~train_pulse &
                         (((state == TRAIN) & train_last) |
                          ((state == DATA) & word_end));
    assign accept      = din_valid & din_ready;
    assign next_word   = accept ? din : IDLE_WORD;
    assign shifted     = {shreg[WIDTH-2:0], 1'b0};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            train_cnt   <= '0;
            train_done  <= 1'b0;
            launch_edge <= 1'b0;
        end else if (train_pulse) begin
            // Restart wins over everything, dropping any word in flight
            state       <= TRAIN;
            shreg       <= TRAIN_WORD;
            bit_cnt     <= '0;
            train_cnt   <= '0;
            train_done  <= 1'b0;
            launch_edge <= fl_sync[1];
        end else begin
            case (state)
                TRAIN: begin
                    if (train_last) begin
                        state       <= DATA;
                        train_done  <= 1'b1;
                        bit_cnt     <= '0;
                        shreg       <= next_word;
                        launch_edge <= fl_sync[1];
                    end else begin
                        train_cnt <= train_cnt + 16'd1;
                        if (word_end) begin
                            bit_cnt     <= '0;
                            shreg       <= TRAIN_WORD;
                            launch_edge <= fl_sync[1];
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            shreg   <= shifted;
                        end
                    end
                end
                DATA: begin
                    if (word_end) begin
                        bit_cnt     <= '0;
                        shreg       <= next_word;
                        launch_edge <= fl_sync[1];
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                        shreg   <= shifted;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Half-cycle delayed copy of the MSB for falling-edge launch
    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) neg_bit <= 1'b0;
        else       neg_bit <= shreg[WIDTH-1];
    end

    assign training = state == TRAIN;
    assign dout     = launch_edge ? neg_bit : shreg[WIDTH-1];

endmodule

// File: tb/tb_serial_tx_launcher.sv
// Bench for serial_tx_launcher: bit-queue reference model plus directed
// and randomized stimulus.
module tb_serial_tx_launcher;

    localparam int         W  = 8;
    localparam logic [7:0] TW = 8'hAA;
    localparam logic [7:0] IW = 8'h3C;
    localparam int         TC = 256;
    localparam int M_IDLE  = 0;
    localparam int M_TRAIN = 1;
    localparam int M_DATA  = 2;

    logic       clk;
    logic       rstn;
    logic       train_start_asyn;
    logic       falling_edge_launch_asyn;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       dout;
    logic       training;
    logic       train_done;
    logic       launch_edge;

    int n_pass;
    int n_total;

    serial_tx_launcher #(
        .WIDTH       (W),
        .TRAIN_WORD  (TW),
        .IDLE_WORD   (IW),
        .TRAIN_CYCLES(TC)
    ) dut (
        .clk                     (clk),
        .rstn                    (rstn),
        .train_start_asyn        (train_start_asyn),
        .falling_edge_launch_asyn(falling_edge_launch_asyn),
        .din                     (din),
        .din_valid               (din_valid),
        .din_ready               (din_ready),
        .dout                    (dout),
        .training                (training),
        .train_done              (train_done),
        .launch_edge             (launch_edge)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Reference model: queue of bits still to be launched for the
    // current word, front = bit on the rising-launch path now.
    bit q[$];
    int mode;
    int words_left;
    bit m_done;
    bit m_launch;
    bit nb;
    bit exp_ready;
    bit sh[3];
    bit fh[2];

    function automatic bit rise_bit();
        return (q.size() > 0) ? q[0] : 1'b0;
    endfunction

    task automatic push_word(input logic [7:0] w);
        for (int i = W - 1; i >= 0; i--) q.push_back(w[i]);
    endtask

    task automatic model_reset();
        q.delete();
        mode       = M_IDLE;
        words_left = 0;
        m_done     = 1'b0;
        m_launch   = 1'b0;
        nb         = 1'b0;
        exp_ready  = 1'b0;
        for (int i = 0; i < 3; i++) sh[i] = 1'b0;
        for (int i = 0; i < 2; i++) fh[i] = 1'b0;
    endtask

    task automatic model_rise();
        bit pulse;
        bit fsync;
        bit acc;
        pulse = sh[1] & ~sh[2];
        fsync = fh[1];
        acc   = exp_ready & din_valid;
        if (pulse) begin
            q.delete();
            push_word(TW);
            mode       = M_TRAIN;
            words_left = TC / W - 1;
            m_done     = 1'b0;
            m_launch   = fsync;
        end else if (mode != M_IDLE) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
                if (mode == M_TRAIN && words_left > 0) begin
                    push_word(TW);
                    words_left--;
                end else begin
                    if (mode == M_TRAIN) begin
                        mode   = M_DATA;
                        m_done = 1'b1;
                    end
                    push_word(acc ? din : IW);
                end
                m_launch = fsync;
            end
        end
        sh[2] = sh[1];
        sh[1] = sh[0];
        sh[0] = train_start_asyn;
        fh[1] = fh[0];
        fh[0] = falling_edge_launch_asyn;
        exp_ready = !(sh[1] & ~sh[2]) && q.size() == 1 &&
                    (mode == M_DATA || (mode == M_TRAIN && words_left == 0));
    endtask

    task automatic check_all();
        chk("dout", 32'(dout), 32'(m_launch ? nb : rise_bit()));
        chk("din_ready", 32'(din_ready), 32'(exp_ready));
        chk("training", 32'(training), 32'(mode == M_TRAIN));
        chk("train_done", 32'(train_done), 32'(m_done));
        chk("launch_edge", 32'(launch_edge), 32'(m_launch));
    endtask

    initial begin : compare
        model_reset();
        forever begin
            @(posedge clk or negedge clk or negedge rstn);
            if (!rstn) begin
                model_reset();
                #1;
                check_all();
            end else if (clk) begin
                model_rise();
                #1;
                check_all();
            end else begin
                nb = rise_bit();
                #1;
                chk("dout_neg", 32'(dout), 32'(m_launch ? nb : rise_bit()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!din_ready && n < 40) begin
            step();
            n++;
        end
        chk("ready_wait_timeout", 32'(n < 40), 32'd1);
    endtask

    initial begin : stim
        int cnt;
        int rc;
        int ts_hold;
        logic [7:0]  tw;
        logic [15:0] cap;
        n_pass = 0;
        n_total = 0;
        rstn = 1'b1;
        train_start_asyn = 1'b0;
        falling_edge_launch_asyn = 1'b0;
        din = 8'h00;
        din_valid = 1'b0;
        #2 rstn = 1'b0;
        repeat (3) step();
        rstn = 1'b1;

        // Idle after reset
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (dout || din_ready || training) cnt++;
        end
        chk("idle_quiet", 32'(cnt), 32'd0);

        // Training entry, length and pattern; input held high afterwards
        din = 8'hC5;
        din_valid = 1'b1;
        train_start_asyn = 1'b1;
        step();
        step();
        chk("train_not_yet", 32'(training), 32'd0);
        step();
        chk("train_entry", 32'(training), 32'd1);
        chk("train_first_bit", 32'(dout), 32'd1);
        cnt = 0;
        tw = 8'h00;
        while (training && cnt < 400) begin
            if (cnt < 8) tw[7-cnt] = dout;
            cnt++;
            step();
        end
        chk("train_len", 32'(cnt), 32'd256);
        chk("train_pattern", 32'(tw), 32'hAA);
        chk("train_done_rise", 32'(train_done), 32'd1);

        // Payload back-to-back, then fill words
        rc = 0;
        cap = '0;
        for (int i = 0; i < 16; i++) begin
            cap[15-i] = dout;
            if (din_ready) rc++;
            if (i == 0) din = 8'h01;
            if (i == 8) din_valid = 1'b0;
            step();
        end
        chk("payload_bits", 32'(cap), 32'hC501);
        chk("ready_pulses", 32'(rc), 32'd2);
        train_start_asyn = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cap[15-i] = dout;
            step();
        end
        chk("idle_word_bits", 32'(cap), 32'h3C3C);

        // Switch to falling launch mid-word
        wait_ready();
        step();
        step();
        falling_edge_launch_asyn = 1'b1;
        repeat (6) step();
        chk("launch_hold", 32'(launch_edge), 32'd0);
        step();
        chk("launch_switch", 32'(launch_edge), 32'd1);
        for (int i = 0; i < 40; i++) begin
            din = 8'($urandom);
            din_valid = 1'($urandom_range(0, 1));
            step();
        end

        // Retrain colliding with an accept
        din_valid = 1'b1;
        din = 8'h5A;
        wait_ready();
        repeat (6) step();
        train_start_asyn = 1'b1;
        step();
        step();
        chk("coll_ready", 32'(din_ready), 32'd0);
        step();
        chk("coll_training", 32'(training), 32'd1);
        chk("coll_done", 32'(train_done), 32'd0);
        train_start_asyn = 1'b0;

        // Randomized traffic with occasional retrain and polarity flips
        ts_hold = 0;
        for (int c = 0; c < 900; c++) begin
            din = 8'($urandom);
            din_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0)
                falling_edge_launch_asyn = ~falling_edge_launch_asyn;
            if (ts_hold > 0) begin
                ts_hold--;
                if (ts_hold == 0) train_start_asyn = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                train_start_asyn = 1'b1;
                ts_hold = $urandom_range(1, 6);
            end
            step();
        end
        train_start_asyn = 1'b0;

        // Reset mid-word with falling launch active
        falling_edge_launch_asyn = 1'b1;
        repeat (11) step();
        rstn = 1'b0;
        #1;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_training", 32'(training), 32'd0);
        repeat (4) step();
        rstn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (dout || training || din_ready) cnt++;
        end
        chk("post_rst_idle", 32'(cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
